// File: rtl/in_port_capture_if.sv
// Switch/button capture port of the CPU input front end.
// slave is the capture block; master drives the raw inputs and the read strobe.
interface in_port_capture_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] SW;
  logic             BTN;
  logic             LEER;
  logic [WIDTH-1:0] DATO_IN;
  logic             VALIDO;
  logic             SOBRE;

  modport master (
    output SW, BTN, LEER,
    input  DATO_IN, VALIDO, SOBRE
  );

  modport slave (
    input  SW, BTN, LEER,
    output DATO_IN, VALIDO, SOBRE
  );
endinterface

// File: rtl/in_port_capture.sv
// Input-port front end: synchronises switches/button, debounces the button and
// latches the switch byte on each debounced press into a one-entry holding register.
module in_port_capture #(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic          CLK,
  input  logic          RST,
  in_port_capture_if.slave bus
);

  typedef enum logic {VACIO, LLENO} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] sw_s1, sw_s2;
  logic             btn_s1, btn_s2;
  logic             btn_d;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  logic [WIDTH-1:0] dato;
  logic             sobre;
  logic             flip;
  logic             capture;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      sw_s1  <= bus.SW;
      sw_s2  <= sw_s1;
      btn_s1 <= bus.BTN;
      btn_s2 <= btn_s1;
    end
  end

  // The debounced level toggles on the same edge that the FSM sees the capture.
  always_comb begin
    flip    = (btn_s2 != btn_d) && (cnt == CNT_LAST);
    capture = flip && btn_s2;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btn_d <= 1'b0;
      cnt   <= '0;
    end else if (btn_s2 == btn_d) begin
      cnt <= '0;
    end else if (flip) begin
      btn_d <= btn_s2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= VACIO;
      dato  <= '0;
      sobre <= 1'b0;
    end else if (state == VACIO) begin
      if (capture) begin
        dato  <= sw_s2;
        state <= LLENO;
      end
    end else begin
      if (capture) begin
        // A read on the capture edge consumes the old byte, so no overrun.
        dato  <= sw_s2;
        sobre <= ~bus.LEER;
      end else if (bus.LEER) begin
        state <= VACIO;
        sobre <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.DATO_IN = dato;
    bus.VALIDO  = (state == LLENO);
    bus.SOBRE   = sobre;
  end

endmodule

// File: doc/in_port_capture.md
Name: in_port_capture

Overview:
- Input-port front end of the 8-bit CPU. Produces the DATO_IN byte that the register-input multiplexer selects when the CPU executes a port read.
- Synchronises the external switch bank and capture button to CLK, then debounces the button.
- On each debounced press, latches the switch byte into a one-entry holding register with a valid/overrun handshake toward the CPU.

Parameters:
- WIDTH, 8, width of the switch bank and DATO_IN.
- DEB_CYCLES, 16, consecutive synchronised cycles the button must differ from its debounced state before that state flips (legal range 1 to 2^CNT_W-1).
- CNT_W, 5, debounce counter width.

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- SW  in  WIDTH  raw external switches, asynchronous to CLK.
- BTN  in  1  raw capture push-button, asynchronous, active-high, bouncy.
- LEER  in  1  one-cycle CPU read strobe; consumes the held byte.
- DATO_IN  out  WIDTH  held switch byte, fed to the register-input multiplexer.
- VALIDO  out  1  DATO_IN holds an unread capture.
- SOBRE  out  1  sticky overrun flag: a capture overwrote an unread byte.

Behaviour:
- Reset (asynchronous, RST=1):
  - Synchronizer flops, debounced button BTN_D and counter all 0.
  - State VACIO; DATO_IN=0, VALIDO=0, SOBRE=0.
  - Reset mid-debounce or while LLENO discards everything; the first press after release is treated as fresh.
- Synchronisation:
  - SW and BTN each pass through two flops (s1, then s2).
  - Only s2 values are used downstream. No combinational path from SW or BTN to any output.
- Debounce:
  - Each cycle, if BTN_s2 == BTN_D, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEB_CYCLES-1 while still differing, the next edge toggles BTN_D and clears the counter.
  - Pulses shorter than DEB_CYCLES synchronised cycles never change BTN_D.
- Capture event: the edge at which BTN_D goes 0->1. Release (1->0) is debounced identically but triggers nothing.
- Capture latency: if BTN is first sampled high at edge 1 and held, BTN_D and VALIDO become 1 after edge DEB_CYCLES+2. DATO_IN = SW_s2 as sampled at that same edge.
- FSM states: VACIO, LLENO.
  - VACIO + capture: load DATO_IN, VALIDO<=1, go to LLENO.
  - VACIO + LEER: ignored; no change.
  - LLENO + LEER only: VALIDO<=0, SOBRE<=0, go to VACIO. DATO_IN keeps its value (not cleared).
  - LLENO + capture only: reload DATO_IN, SOBRE<=1, stay in LLENO.
  - LLENO + LEER and capture on the same edge: the read consumes the old byte, new byte loads. VALIDO stays 1, SOBRE<=0, stay in LLENO.
- SOBRE rules:
  - Sticky; cleared only by LEER or RST.
  - A second overrun while already set keeps it 1.
- VALIDO == (state == LLENO) at all times.
- LEER held high for several cycles behaves as one read per cycle. After the first cycle in VACIO, the extra reads are ignored.

Test Plan:
- Reset (DEB_CYCLES=4): assert RST asynchronously between edges -> DATO_IN=0x00, VALIDO=0, SOBRE=0 immediately, with no clock edge required.
- Clean press: SW=0xA5; BTN high from edge 1, held 20 cycles -> VALIDO rises after edge 6 exactly; DATO_IN=0xA5, SOBRE=0. Release causes no change.
- Bounce rejection: BTN high 3 cycles, low 1, high 2, low -> VALIDO stays 0. Then a clean press with SW=0x3C -> DATO_IN=0x3C.
- Read handshake: in LLENO with DATO_IN=0x3C, pulse LEER for 1 cycle -> VALIDO=0 next edge, DATO_IN still 0x3C. A further LEER pulse -> no change.
- Overrun: capture 0x11, no read, then capture 0x22 -> DATO_IN=0x22, VALIDO=1, SOBRE=1. Capture 0x33 -> SOBRE stays 1. LEER -> VALIDO=0, SOBRE=0.
- Simultaneous event: in LLENO holding 0x44 with SOBRE=1, pulse LEER on the capture edge with SW=0x55 -> DATO_IN=0x55, VALIDO=1, SOBRE=0. Also assert RST mid-debounce, then release RST -> no capture without a full new press.
